// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-input select path. It drives s1/s0, registers the chosen word and hands it on with valid/ready.
// Optional macro MUX4_ARB_BURST_EN: the granted source keeps the grant for up to BURST_LEN back-to-back words.
module mux4_rr_arbiter #(
    parameter int N         = 8,
    parameter int BURST_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic         s1,
    output logic         s0,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state_q, state_d;
    logic [1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]   sel_q, sel_d;
    logic [3:0]   gnt_q, gnt_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic         found;
    logic [1:0]   win;
    logic         accept;

`ifdef MUX4_ARB_BURST_EN
    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
    logic [3:0] burst_cnt_q, burst_cnt_d;
`endif

    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("BURST_LEN must be in 1..16");
    end

    // Searches ptr+1, ptr+2, ... (mod 4). The descending loop lets the nearest requester win.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [N-1:0] mux4(input logic [1:0] s, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic [N-1:0] c,
                                          input logic [N-1:0] d);
        logic [N-1:0] y;
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
        return y;
    endfunction

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef MUX4_ARB_BURST_EN
        burst_cnt_d = burst_cnt_q;
`endif
        {found, win} = rr_pick(req, rr_ptr_q);
        accept       = (state_q == BUSY) && out_valid_q && out_ready;
        ack          = accept ? gnt_q : 4'b0000;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d       = 4'b0001 << win;
                    sel_d       = win;
                    out_data_d  = mux4(win, A, B, C, D);
                    out_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            default: begin
                if (accept) begin
`ifdef MUX4_ARB_BURST_EN
                    if (req[sel_q] && (burst_cnt_q < BURST_LAST)) begin
                        out_data_d  = mux4(sel_q, A, B, C, D);
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        rr_ptr_d    = sel_q;
                        out_valid_d = 1'b0;
                        gnt_d       = 4'b0000;
                        burst_cnt_d = 4'd0;
                        state_d     = IDLE;
                    end
`else
                    rr_ptr_d    = sel_q;
                    out_valid_d = 1'b0;
                    gnt_d       = 4'b0000;
                    state_d     = IDLE;
`endif
                end
            end
        endcase
    end

    // rr_ptr resets to 3 so that source A has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd3;
            sel_q       <= 2'd0;
            gnt_q       <= 4'b0000;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef MUX4_ARB_BURST_EN
            burst_cnt_q <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef MUX4_ARB_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
